// File: rtl/rx_cmd_ctrl.sv
// rtl/rx_cmd_ctrl.sv - receive-side command sequencer: byte frames to regfile/ALU control and TX bytes
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module rx_cmd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int ALU_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Vld,
  input  logic [ALU_W-1:0]      ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  FIFO_FULL,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CLK_EN,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);

  localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_ALU_A,
    S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_TX_BYTE0, S_TX_BYTE1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ALU_W-1:0]      rslt_q, rslt_d;
  logic                  single_q, single_d;

  logic                  wr_en_d, rd_en_d, alu_en_d, clk_en_d, tx_vld_d;
  logic [ADDR_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0] wr_data_d, tx_data_d;
  logic [3:0]            alu_fun_d;
  logic                  timeout;

`ifdef CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timed;
  logic          err_q;

  // Only the byte-collecting states are timed; waits on regfile/ALU/FIFO are not.
  always_comb begin
    timed   = state_q inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_A, S_ALU_B, S_ALU_FUN};
    timeout = timed && !RX_D_VLD && (cnt_q == CW'(TIMEOUT_CYC - 1));
    cnt_d   = '0;
    if (timed && !RX_D_VLD && !timeout) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout;
    end
  end

  assign CMD_ERR = err_q;
`else
  assign timeout = 1'b0;
  assign CMD_ERR = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rslt_d    = rslt_q;
    single_d  = single_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
    address_d = Address;
    wr_data_d = WrData;
    alu_fun_d = ALU_FUN;
    alu_en_d  = ALU_EN;
    clk_en_d  = CLK_EN;
    tx_data_d = TX_P_DATA;

    unique case (state_q)
      S_IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          OP_WR:     state_d = S_WR_ADDR;
          OP_RD:     state_d = S_RD_ADDR;
          OP_ALU_OP: state_d = S_ALU_A;
          OP_ALU:    state_d = S_ALU_FUN;
          default:   state_d = S_IDLE;
        endcase
      end
      S_WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = S_WR_DATA;
      end
      S_WR_DATA: if (RX_D_VLD) begin
        wr_en_d   = 1'b1;
        address_d = addr_q;
        wr_data_d = RX_P_DATA;
        state_d   = S_IDLE;
      end
      S_RD_ADDR: if (RX_D_VLD) begin
        rd_en_d   = 1'b1;
        address_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: if (RdData_Vld) begin
        rslt_d   = ALU_W'(RdData);
        single_d = 1'b1;
        state_d  = S_TX_BYTE0;
      end
      S_ALU_A: if (RX_D_VLD) begin
        wr_en_d   = 1'b1;
        address_d = ADDR_WIDTH'(0);
        wr_data_d = RX_P_DATA;
        state_d   = S_ALU_B;
      end
      S_ALU_B: if (RX_D_VLD) begin
        wr_en_d   = 1'b1;
        address_d = ADDR_WIDTH'(1);
        wr_data_d = RX_P_DATA;
        state_d   = S_ALU_FUN;
      end
      S_ALU_FUN: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[3:0];
        alu_en_d  = 1'b1;
        clk_en_d  = 1'b1;
        state_d   = S_ALU_WAIT;
      end
      S_ALU_WAIT: if (ALU_OUT_VLD) begin
        rslt_d   = ALU_OUT;
        single_d = 1'b0;
        alu_en_d = 1'b0;
        clk_en_d = 1'b0;
        state_d  = S_TX_BYTE0;
      end
      // TX strobes only go out while the FIFO has room; otherwise hold position.
      S_TX_BYTE0: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = rslt_q[DATA_WIDTH-1:0];
        state_d   = single_q ? S_IDLE : S_TX_BYTE1;
      end
      S_TX_BYTE1: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = rslt_q[ALU_W-1:DATA_WIDTH];
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) state_d = S_IDLE;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rslt_q    <= '0;
      single_q  <= 1'b0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      ALU_EN    <= 1'b0;
      ALU_FUN   <= '0;
      CLK_EN    <= 1'b0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rslt_q    <= rslt_d;
      single_q  <= single_d;
      WrEn      <= wr_en_d;
      RdEn      <= rd_en_d;
      Address   <= address_d;
      WrData    <= wr_data_d;
      ALU_EN    <= alu_en_d;
      ALU_FUN   <= alu_fun_d;
      CLK_EN    <= clk_en_d;
      TX_P_DATA <= tx_data_d;
      TX_D_VLD  <= tx_vld_d;
    end
  end

endmodule
